// File: rtl/uart_rx_fifo.sv
// UART receiver with framing/parity checks feeding a show-ahead receive FIFO.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               rx,
   input  logic                               rd_en,
   output logic [DATA_BITS-1:0]               rd_data,
   output logic                               rd_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               frame_err,
   output logic                               parity_err,
   output logic                               overrun
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH+1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t                                 state;
   logic                                   rx_meta, rxs;
   logic [CW-1:0]                          cnt;
   logic [3:0]                             bit_cnt;
   logic [DATA_BITS-1:0]                   shreg;
   logic                                   stop_bad, par_bad;
   logic [FIFO_DEPTH-1:0][DATA_BITS-1:0]   mem;
   logic [PW-1:0]                          wr_ptr, rd_ptr;
   logic                                   tick, last_stop, frame_ok, full, pop, push;

   always_ff @(posedge clock or posedge reset)
      if (reset) {rx_meta, rxs} <= 2'b11;
      else       {rx_meta, rxs} <= {rx, rx_meta};

   assign tick      = (cnt == ((state == START) ? HALF : FULL));
   assign last_stop = (state == STOP) && tick && (bit_cnt == 4'(STOP_BITS-1));
   assign frame_ok  = last_stop && rxs && !stop_bad && !par_bad;
   assign full      = (fifo_count == NW'(FIFO_DEPTH));
   assign pop       = rd_en && rd_valid;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push      = frame_ok && (!full || pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         stop_bad  <= 1'b0;
         par_bad   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         cnt       <= cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt      <= '0;
               bit_cnt  <= '0;
               stop_bad <= 1'b0;
               par_bad  <= 1'b0;
               if (!rxs) state <= START;
            end
            START: if (tick) begin
               cnt   <= '0;
               state <= rxs ? IDLE : DATA;
            end
            DATA: if (tick) begin
               cnt   <= '0;
               shreg <= {rxs, shreg[DATA_BITS-1:1]};
               if (bit_cnt == 4'(DATA_BITS-1)) begin
                  bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                  state   <= PARITY;
`else
                  state   <= STOP;
`endif
               end else
                  bit_cnt <= bit_cnt + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
               cnt     <= '0;
               par_bad <= (rxs != ((^shreg) ^ (PARITY_ODD != 0)));
               state   <= STOP;
            end
`endif
            STOP: if (tick) begin
               cnt <= '0;
               if (bit_cnt == 4'(STOP_BITS-1)) begin
                  if (stop_bad || !rxs) begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end else begin
                     overrun <= !par_bad && full && !pop;
                     state   <= IDLE;
                  end
               end else begin
                  stop_bad <= stop_bad | !rxs;
                  bit_cnt  <= bit_cnt + 1'b1;
               end
            end
            WAIT_HIGH: if (rxs) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock or posedge reset)
      if (reset) parity_err <= 1'b0;
      else       parity_err <= last_stop && rxs && !stop_bad && par_bad;
`else
   logic unused_par;
   assign unused_par = (PARITY_ODD != 0);
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign rd_data  = mem[rd_ptr];
   assign rd_valid = (fifo_count != '0);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted words are queued when sent and checked on read.
module tb_uart_rx_fifo;
   localparam int CPB  = 16;
   localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int PUSH_CYC = CPB/2 + (8 + P + 1)*CPB;

   logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, frame_err, parity_err, overrun;
   logic [2:0] fifo_count;

   int n_chk = 0, n_err = 0;
   int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
   logic [7:0] exp_q[$];

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4),
                  .PARITY_ODD(PODD)) dut (
      .clock(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .fifo_count(fifo_count), .frame_err(frame_err),
      .parity_err(parity_err), .overrun(overrun));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun)    ov_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
      rx = 1'b0; tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i]; tick(CPB);
      end
      if (P == 1) begin
         rx = par_v; tick(CPB);
      end
      rx = stop_v; tick(CPB);
   endtask

   task automatic send_good(input logic [7:0] d);
      exp_q.push_back(d);
      send_frame(d, 1'b1, (^d) ^ PODD[0]);
   endtask

   task automatic drain();
      int n = 0;
      while (rd_valid && n < 16) begin
         if (exp_q.size() == 0) chk("extra_word", {24'h0, rd_data}, 32'hdead);
         else                   chk("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
         rd_en = 1'b1;
         tick(1);
         n++;
      end
      rd_en = 1'b0;
      chk("queue_drained", exp_q.size(), 0);
      chk("empty_after_drain", rd_valid, 0);
   endtask

   initial begin
      int fe0, ov0, pe0;
      tick(3);
      chk("rst_valid", rd_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_flags", {frame_err, parity_err, overrun}, 0);
      reset = 1'b0;
      tick(5);

      // single frame, latency check
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1, (^8'hA5) ^ PODD[0]);
         begin
            tick(PUSH_CYC + 2);
            chk("valid_before_push", rd_valid, 0);
            tick(1);
            chk("valid_after_push", rd_valid, 1);
            chk("count_one", fifo_count, 1);
            chk("head_a5", rd_data, 8'hA5);
         end
      join
      tick(10);
      drain();
      chk("count_zero", fifo_count, 0);

      // back-to-back frames into full FIFO
      ov0 = ov_cnt;
      for (int d = 1; d <= 5; d++) begin
         if (d < 5) send_good(8'(d));
         else       send_frame(8'(d), 1'b1, (^8'(d)) ^ PODD[0]);
      end
      tick(10);
      chk("count_full", fifo_count, 4);
      chk("overrun_pulses", ov_cnt - ov0, 1);
      drain();

      // framing error then break
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, (^8'h3C) ^ PODD[0]);
      tick(40);
      chk("frame_err_pulses", fe_cnt - fe0, 1);
      chk("frame_err_nopush", fifo_count, 0);
      rx = 1'b1;
      tick(20);
      send_good(8'h11);
      tick(10);
      drain();
      chk("frame_err_once", fe_cnt - fe0, 1);

      // false start
      fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
      rx = 1'b0; tick(4);
      rx = 1'b1; tick(40);
      chk("glitch_nopush", fifo_count, 0);
      chk("glitch_noflags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
      send_good(8'h66);
      tick(10);
      drain();

      if (P == 1) begin
         pe0 = pe_cnt;
         send_frame(8'h07, 1'b1, ~((^8'h07) ^ PODD[0]));
         tick(10);
         chk("parity_err_pulse", pe_cnt - pe0, 1);
         chk("parity_nopush", fifo_count, 0);
         send_good(8'h07);
         tick(10);
         drain();
         chk("parity_good_noerr", pe_cnt - pe0, 1);
      end

      // reset mid-frame with one word buffered
      send_good(8'h42);
      tick(10);
      chk("pre_reset_count", fifo_count, 1);
      exp_q.delete();
      fork
         send_frame(8'h99, 1'b1, (^8'h99) ^ PODD[0]);
         begin
            tick(72);
            reset = 1'b1;
            #1;
            chk("reset_count", fifo_count, 0);
            chk("reset_valid", rd_valid, 0);
         end
      join
      rx = 1'b1;
      tick(4);
      reset = 1'b0;
      tick(4);
      send_good(8'h5A);
      tick(10);
      chk("post_reset_count", fifo_count, 1);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
